pll_lock_monitor: RTL

- Sits directly downstream of the PLL and runs in the PLL output clock domain.
- Measures how many output-clock cycles occur in each reference period and compares the count against the programmed multiplier n.
- Reports lock, a sticky loss-of-lock flag and the latest measurement, for readback through the AHB subordinate register file.

---
 rtl/pll_pkg.sv | 19 +
 rtl/pll_period_counter.sv | 51 +++++
 rtl/pll_lock_monitor.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/pll_pkg.sv
// Shared definitions for the PLL lock monitor.
//   pll_state_e        - monitor FSM state encoding
//   DefaultCntW        - default period counter width
//   DefaultLockWindows - default count of good windows needed for lock
//   DefaultWinCntW     - default good-window counter width
package pll_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAcquire,
        StTrack,
        StLocked
    } pll_state_e;

    localparam int unsigned DefaultCntW        = 10;
    localparam int unsigned DefaultLockWindows = 8;
    localparam int unsigned DefaultWinCntW     = 4;

endpackage

// File: rtl/pll_period_counter.sv
// Reference-period counter for the PLL lock monitor.
// Detects rising edges of the synchronized reference, counts output-clock cycles per
// reference period and flags windows that never close.
//   clk      - PLL output clock
//   rst      - synchronous active-high reset
//   active   - counting enabled (monitor enabled and out of idle)
//   ref_sync - reference clock, already synchronized into clk
//   count    - cycles elapsed in the current window (edge cycle counts as 1)
//   win_done - reference edge seen while active; count holds the finished window length
//   timeout  - counter saturated with no edge; window is abandoned
module pll_period_counter
    import pll_pkg::*;
#(
    parameter int unsigned CNT_W = DefaultCntW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             active,
    input  logic             ref_sync,
    output logic [CNT_W-1:0] count,
    output logic             win_done,
    output logic             timeout
);

    logic             ref_q;
    logic             ref_edge;
    logic [CNT_W-1:0] cnt_q;

    assign ref_edge = ref_sync & ~ref_q;
    assign win_done = active & ref_edge;
    assign timeout  = active & ~ref_edge & (cnt_q == '1);
    assign count    = cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ref_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            ref_q <= ref_sync;
            if (!active) begin
                cnt_q <= '0;
            end else if (ref_edge || timeout) begin
                // The edge (or timeout) cycle is cycle 1 of the next window.
                cnt_q <= CNT_W'(1);
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pll_lock_monitor.sv
// PLL lock monitor: compares output-clock cycles per reference period against n and
// tracks lock over consecutive in-tolerance windows.
//   clk, rst    - PLL output clock, synchronous active-high reset
//   enable      - monitor enable (follows PLL enable)
//   n, tol      - expected cycles per reference period, allowed absolute deviation
//   ref_sync    - synchronized reference clock level
//   clr_loss    - pulse clearing loss_sticky (a simultaneous loss wins)
//   locked      - lock indication
//   loss_sticky - set whenever lock is lost
//   meas_valid  - one-cycle pulse with each new measurement
//   meas_count  - length of the last completed window
//   freq_err    - signed meas_count - n
module pll_lock_monitor
    import pll_pkg::*;
#(
    parameter int unsigned CNT_W        = DefaultCntW,
    parameter int unsigned LOCK_WINDOWS = DefaultLockWindows,
    parameter int unsigned WIN_CNT_W    = DefaultWinCntW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [7:0]       n,
    input  logic [3:0]       tol,
    input  logic             ref_sync,
    input  logic             clr_loss,
    output logic             locked,
    output logic             loss_sticky,
    output logic             meas_valid,
    output logic [CNT_W-1:0] meas_count,
    output logic [CNT_W:0]   freq_err
);

    localparam logic [WIN_CNT_W-1:0] LockWin = WIN_CNT_W'(LOCK_WINDOWS);

    pll_state_e           state_q, state_d;
    logic [WIN_CNT_W-1:0] good_q, good_d;
    logic                 locked_q, locked_d;
    logic                 loss_q, loss_set;
    logic                 meas_valid_q;
    logic [CNT_W-1:0]     meas_count_q;
    logic [CNT_W:0]       freq_err_q;

    logic             active;
    logic [CNT_W-1:0] count;
    logic             win_done;
    logic             timeout;
    logic [CNT_W:0]   diff;
    logic [CNT_W:0]   diff_abs;
    logic             in_tol;
    logic             tracking;
    logic             eval;
    logic             good_win;
    logic             bad_win;

    // Gating on enable clears the counter on the same edge the FSM drops to idle.
    assign active = (state_q != StIdle) && enable;

    pll_period_counter #(
        .CNT_W (CNT_W)
    ) u_period_counter (
        .clk      (clk),
        .rst      (rst),
        .active   (active),
        .ref_sync (ref_sync),
        .count    (count),
        .win_done (win_done),
        .timeout  (timeout)
    );

    assign diff     = {1'b0, count} - {{(CNT_W + 1 - 8){1'b0}}, n};
    assign diff_abs = diff[CNT_W] ? (~diff + (CNT_W + 1)'(1)) : diff;
    assign in_tol   = (n != 8'd0) && (diff_abs <= {{(CNT_W + 1 - 4){1'b0}}, tol});

    assign tracking = (state_q == StTrack) || (state_q == StLocked);
    assign eval     = tracking & win_done;
    assign good_win = eval & in_tol;
    assign bad_win  = tracking & ((win_done & ~in_tol) | timeout);

    always_comb begin
        state_d  = state_q;
        good_d   = good_q;
        locked_d = locked_q;
        loss_set = 1'b0;
        unique case (state_q)
            StIdle: begin
                good_d   = '0;
                locked_d = 1'b0;
                if (enable) state_d = StAcquire;
            end
            StAcquire: begin
                // First edge only opens a window.
                if (win_done) state_d = StTrack;
            end
            StTrack: begin
                if (good_win) begin
                    good_d = good_q + WIN_CNT_W'(1);
                    if (good_q + WIN_CNT_W'(1) == LockWin) begin
                        state_d  = StLocked;
                        locked_d = 1'b1;
                    end
                end else if (bad_win) begin
                    good_d = '0;
                end
            end
            StLocked: begin
                if (bad_win) begin
                    state_d  = StTrack;
                    locked_d = 1'b0;
                    loss_set = 1'b1;
                    good_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase
        if (!enable) begin
            state_d  = StIdle;
            good_d   = '0;
            locked_d = 1'b0;
            loss_set = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            good_q       <= '0;
            locked_q     <= 1'b0;
            loss_q       <= 1'b0;
            meas_valid_q <= 1'b0;
            meas_count_q <= '0;
            freq_err_q   <= '0;
        end else begin
            state_q      <= state_d;
            good_q       <= good_d;
            locked_q     <= locked_d;
            meas_valid_q <= eval;
            if (loss_set) begin
                loss_q <= 1'b1;
            end else if (clr_loss) begin
                loss_q <= 1'b0;
            end
            if (eval) begin
                meas_count_q <= count;
                freq_err_q   <= diff;
            end
        end
    end

    assign locked      = locked_q;
    assign loss_sticky = loss_q;
    assign meas_valid  = meas_valid_q;
    assign meas_count  = meas_count_q;
    assign freq_err    = freq_err_q;

endmodule
